// File: rtl/sha256_stream_packer_if.sv
// sha256_stream_packer_if
// Groups the byte-stream handshake and the hash-core command/status
// signals of the SHA-256 stream packer.
//   master : the packer (consumes bytes, commands the hash core)
//   slave  : the environment (byte source plus hash core)
// Signals:
//   s_valid/s_data/s_last/s_ready : byte stream, accepted on s_valid & s_ready
//   start/update/data_in/bytes_valid/finalize : hash-core commands
//   hash_valid : digest-ready pulse from the hash core
//   timeout    : watchdog expiry pulse
interface sha256_stream_packer_if;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        start;
    logic        update;
    logic [31:0] data_in;
    logic [2:0]  bytes_valid;
    logic        finalize;
    logic        hash_valid;
    logic        timeout;

    modport master (
        input  s_valid, s_data, s_last, hash_valid,
        output s_ready, start, update, data_in, bytes_valid, finalize, timeout
    );

    modport slave (
        output s_valid, s_data, s_last, hash_valid,
        input  s_ready, start, update, data_in, bytes_valid, finalize, timeout
    );
endinterface

// File: rtl/sha256_stream_packer.sv
// sha256_stream_packer
// Packs a byte stream big-endian into 32-bit words for a SHA-256 core.
// Each message: PRIME (start pulse) -> ACCEPT (bytes packed, full words
// issued as update) -> FLUSH (final, possibly partial word) -> FINAL
// (finalize pulse) -> WAIT (until hash_valid) -> PRIME.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : sha256_stream_packer_if.master (stream + hash-core signals)
// Option: define SHA256_STREAM_PACKER_WATCHDOG_EN to add a 12-bit WAIT
// watchdog that pulses timeout and re-primes after 4095 idle WAIT cycles.
module sha256_stream_packer (
    input  logic                          clk,
    input  logic                          reset,
    sha256_stream_packer_if.master        bus
);
    typedef enum logic [2:0] {PRIME, ACCEPT, FLUSH, FINAL, WAIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        upd_q, upd_d;
    logic [2:0]  bv_q, bv_d;
    logic        timeout_w;
`ifdef SHA256_STREAM_PACKER_WATCHDOG_EN
    logic [11:0] wdog_q, wdog_d;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        upd_d     = 1'b0;
        bv_d      = bv_q;
        timeout_w = 1'b0;
`ifdef SHA256_STREAM_PACKER_WATCHDOG_EN
        wdog_d    = wdog_q;
`endif
        case (state_q)
            PRIME: state_d = ACCEPT;
            ACCEPT: begin
                if (bus.s_valid) begin
                    // Byte 0 rebuilds the word so stale bytes of the previous
                    // word never leak into the unused low bytes of a partial.
                    case (idx_q)
                        2'd0: word_d = {bus.s_data, 24'h0};
                        2'd1: word_d = {word_q[31:24], bus.s_data, 16'h0};
                        2'd2: word_d = {word_q[31:16], bus.s_data, 8'h0};
                        default: word_d = {word_q[31:8], bus.s_data};
                    endcase
                    bv_d  = {1'b0, idx_q} + 3'd1;
                    idx_d = idx_q + 2'd1;
                    if (bus.s_last) begin
                        // The flush update is issued from FLUSH via upd_q.
                        upd_d   = 1'b1;
                        idx_d   = 2'd0;
                        state_d = FLUSH;
                    end else if (idx_q == 2'd3) begin
                        upd_d = 1'b1;
                    end
                end
            end
            FLUSH: state_d = FINAL;
            FINAL: begin
                state_d = WAIT;
`ifdef SHA256_STREAM_PACKER_WATCHDOG_EN
                wdog_d  = 12'h0;
`endif
            end
            WAIT: begin
                if (bus.hash_valid) begin
                    state_d = PRIME;
`ifdef SHA256_STREAM_PACKER_WATCHDOG_EN
                end else if (wdog_q == 12'hFFF) begin
                    timeout_w = 1'b1;
                    state_d   = PRIME;
                end else begin
                    wdog_d = wdog_q + 12'd1;
`endif
                end
            end
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PRIME;
            idx_q   <= 2'd0;
            word_q  <= 32'h0;
            upd_q   <= 1'b0;
            bv_q    <= 3'd0;
`ifdef SHA256_STREAM_PACKER_WATCHDOG_EN
            wdog_q  <= 12'h0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            upd_q   <= upd_d;
            bv_q    <= bv_d;
`ifdef SHA256_STREAM_PACKER_WATCHDOG_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    assign bus.start       = (state_q == PRIME);
    assign bus.s_ready     = (state_q == ACCEPT);
    assign bus.finalize    = (state_q == FINAL);
    assign bus.update      = upd_q;
    assign bus.data_in     = upd_q ? word_q : 32'h0;
    assign bus.bytes_valid = upd_q ? bv_q : 3'd0;
`ifdef SHA256_STREAM_PACKER_WATCHDOG_EN
    assign bus.timeout     = timeout_w;
`else
    assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_stream_packer.sv
// Directed bench for sha256_stream_packer: reset state, "abc", exact-word,
// word+partial with gaps, hash_valid outside/inside WAIT, mid-message reset
// and the WAIT watchdog behaviour for the selected build.
module tb_sha256_stream_packer;
    logic clk;
    logic reset;
    int   nvec;
    int   nerr;

    sha256_stream_packer_if bus();

    sha256_stream_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte for one cycle (caller guarantees ACCEPT).
    task automatic put(input logic [7:0] d, input logic last);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        tick;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = 8'h0;
    endtask

    // From FINAL: step into WAIT, pulse hash_valid, land in ACCEPT.
    task automatic release_wait;
        tick;
        bus.hash_valid = 1'b1;
        tick;
        bus.hash_valid = 1'b0;
        tick;
    endtask

    initial begin
        logic seen_to;
        logic seen_rdy;
        nvec = 0;
        nerr = 0;
        bus.s_valid    = 1'b0;
        bus.s_data     = 8'h0;
        bus.s_last     = 1'b0;
        bus.hash_valid = 1'b0;
        reset          = 1'b1;
        tick;
        tick;

        // Reset state
        chk("rst_s_ready",  bus.s_ready, 0);
        chk("rst_update",   bus.update, 0);
        chk("rst_data_in",  bus.data_in, 0);
        chk("rst_bv",       bus.bytes_valid, 0);
        chk("rst_finalize", bus.finalize, 0);
        chk("rst_timeout",  bus.timeout, 0);
        reset = 1'b0;
        chk("prime_start",   bus.start, 1);
        chk("prime_s_ready", bus.s_ready, 0);
        tick;
        chk("accept_s_ready", bus.s_ready, 1);
        chk("accept_start",   bus.start, 0);

        // "abc"
        put(8'h61, 1'b0);
        chk("abc_no_upd", bus.update, 0);
        put(8'h62, 1'b0);
        put(8'h63, 1'b1);
        chk("abc_update",   bus.update, 1);
        chk("abc_data",     bus.data_in, 32'h61626300);
        chk("abc_bv",       bus.bytes_valid, 3);
        chk("abc_s_ready",  bus.s_ready, 0);
        chk("abc_fin_early", bus.finalize, 0);
        tick;
        chk("abc_finalize", bus.finalize, 1);
        chk("abc_upd_off",  bus.update, 0);
        chk("abc_data_off", bus.data_in, 0);
        chk("abc_bv_off",   bus.bytes_valid, 0);
        tick;
        chk("abc_fin_once", bus.finalize, 0);
        chk("wait_s_ready", bus.s_ready, 0);
        repeat (5) tick;
        chk("wait_hold",    bus.s_ready, 0);
        bus.hash_valid = 1'b1;
        tick;
        bus.hash_valid = 1'b0;
        chk("hv_start",     bus.start, 1);
        chk("hv_s_ready0",  bus.s_ready, 0);
        tick;
        chk("hv_s_ready1",  bus.s_ready, 1);
        chk("hv_start_off", bus.start, 0);

        // Exactly four bytes, last on the fourth
        put(8'h01, 1'b0);
        put(8'h02, 1'b0);
        put(8'h03, 1'b0);
        put(8'h04, 1'b1);
        chk("w4_update", bus.update, 1);
        chk("w4_data",   bus.data_in, 32'h01020304);
        chk("w4_bv",     bus.bytes_valid, 4);
        tick;
        chk("w4_finalize", bus.finalize, 1);
        chk("w4_no_extra", bus.update, 0);
        release_wait;

        // hash_valid in ACCEPT is ignored
        bus.hash_valid = 1'b1;
        tick;
        bus.hash_valid = 1'b0;
        chk("hv_acc_ready", bus.s_ready, 1);
        chk("hv_acc_start", bus.start, 0);

        // Five bytes with s_valid gaps
        put(8'h01, 1'b0);
        chk("w5_gap_upd0", bus.update, 0);
        tick;
        put(8'h02, 1'b0);
        put(8'h03, 1'b0);
        tick;
        tick;
        put(8'h04, 1'b0);
        chk("w5_update1", bus.update, 1);
        chk("w5_data1",   bus.data_in, 32'h01020304);
        chk("w5_bv1",     bus.bytes_valid, 4);
        tick;
        chk("w5_gap_upd",  bus.update, 0);
        chk("w5_gap_data", bus.data_in, 0);
        put(8'h05, 1'b1);
        chk("w5_update2", bus.update, 1);
        chk("w5_data2",   bus.data_in, 32'h05000000);
        chk("w5_bv2",     bus.bytes_valid, 1);
        tick;
        chk("w5_finalize", bus.finalize, 1);
        release_wait;

        // Reset after two accepted bytes
        put(8'hAA, 1'b0);
        put(8'hBB, 1'b0);
        reset = 1'b1;
        tick;
        chk("mrst_update",   bus.update, 0);
        chk("mrst_finalize", bus.finalize, 0);
        chk("mrst_s_ready",  bus.s_ready, 0);
        reset = 1'b0;
        chk("mrst_start",    bus.start, 1);
        tick;
        chk("mrst_accept",   bus.s_ready, 1);
        put(8'h11, 1'b0);
        put(8'h22, 1'b0);
        put(8'h33, 1'b0);
        put(8'h44, 1'b1);
        chk("mrst_data", bus.data_in, 32'h11223344);
        chk("mrst_bv",   bus.bytes_valid, 4);
        tick;
        chk("mrst_finalize2", bus.finalize, 1);
        tick;

        // Now in the first WAIT cycle
        seen_to  = 1'b0;
        seen_rdy = 1'b0;
`ifdef SHA256_STREAM_PACKER_WATCHDOG_EN
        for (int i = 0; i < 4095; i++) begin
            seen_to  = seen_to | bus.timeout;
            seen_rdy = seen_rdy | bus.s_ready;
            tick;
        end
        chk("wd_early_to",  seen_to, 0);
        chk("wd_s_ready",   seen_rdy, 0);
        chk("wd_timeout",   bus.timeout, 1);
        tick;
        chk("wd_to_once",   bus.timeout, 0);
        chk("wd_start",     bus.start, 1);
        tick;
        chk("wd_accept",    bus.s_ready, 1);
`else
        for (int i = 0; i < 4200; i++) begin
            seen_to  = seen_to | bus.timeout;
            seen_rdy = seen_rdy | bus.s_ready;
            tick;
        end
        chk("nowd_timeout", seen_to, 0);
        chk("nowd_s_ready", seen_rdy, 0);
        bus.hash_valid = 1'b1;
        tick;
        bus.hash_valid = 1'b0;
        chk("nowd_start",   bus.start, 1);
        tick;
        chk("nowd_accept",  bus.s_ready, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
